// File: rtl/nanci_pkg.sv
// nanci_pkg: shared word-field helpers, default widths and collector state enum for the Nanci sorter.
// Contents: state_e {IDLE, COLLECT, DRAIN}; DEF_ADDR_WIDTH/DEF_DATA_WIDTH/DEF_MAX_INT;
//           addr_lsb/addr_msb give the addr field position inside a {addr, data} word.
package nanci_pkg;
    typedef enum logic [1:0] {IDLE, COLLECT, DRAIN} state_e;
    localparam int unsigned DEF_ADDR_WIDTH = 3;
    localparam int unsigned DEF_DATA_WIDTH = 3;
    localparam logic [DEF_ADDR_WIDTH+DEF_DATA_WIDTH-1:0] DEF_MAX_INT = '1;
    function automatic int unsigned addr_lsb(input int unsigned dw);
        return dw;
    endfunction
    function automatic int unsigned addr_msb(input int unsigned aw, input int unsigned dw);
        return aw + dw - 1;
    endfunction
endpackage

// File: rtl/nanci_sort_collector_if.sv
// nanci_sort_collector_if: PE capture, control and drain-stream signals of the sort collector.
// master: PE/host side (drives i_PE, i_start, i_capture, i_flush, i_ready).
// slave:  collector side (drives o_word, o_valid, o_done, o_busy, o_count, o_err).
interface nanci_sort_collector_if #(
    parameter int N          = 8,
    parameter int ADDR_WIDTH = 3,
    parameter int DATA_WIDTH = 3
);
    localparam int W  = ADDR_WIDTH + DATA_WIDTH;
    localparam int CW = $clog2(N + 1);
    logic [W-1:0]  i_PE;
    logic          i_start;
    logic          i_capture;
    logic          i_flush;
    logic [W-1:0]  o_word;
    logic          o_valid;
    logic          i_ready;
    logic          o_done;
    logic          o_busy;
    logic [CW-1:0] o_count;
    logic          o_err;
    modport master (
        output i_PE, i_start, i_capture, i_flush, i_ready,
        input  o_word, o_valid, o_done, o_busy, o_count, o_err
    );
    modport slave (
        input  i_PE, i_start, i_capture, i_flush, i_ready,
        output o_word, o_valid, o_done, o_busy, o_count, o_err
    );
endinterface

// File: rtl/nanci_slot_bank.sv
// nanci_slot_bank: N x DATA_WIDTH result slots with a full bitmap, one write port, one async read port.
// Ports: clk, rst_n (async low, empties all slots), clr_i (sync empty-all), we_i/waddr_i/wdata_i (write),
//        raddr_i -> rdata_o/rfull_o (combinational read), full_o (whole occupancy bitmap).
module nanci_slot_bank #(
    parameter int N          = 8,
    parameter int ADDR_WIDTH = 3,
    parameter int DATA_WIDTH = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clr_i,
    input  logic                  we_i,
    input  logic [ADDR_WIDTH-1:0] waddr_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    input  logic [ADDR_WIDTH-1:0] raddr_i,
    output logic [DATA_WIDTH-1:0] rdata_o,
    output logic                  rfull_o,
    output logic [N-1:0]          full_o
);
    logic [DATA_WIDTH-1:0] mem_q [N];
    logic [N-1:0]          full_q;

    // Only the bitmap needs reset; data of an empty slot is never observed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) full_q <= '0;
        else if (clr_i) full_q <= '0;
        else if (we_i) full_q[waddr_i] <= 1'b1;
    end

    always_ff @(posedge clk) begin
        if (we_i) mem_q[waddr_i] <= wdata_i;
    end

    assign rdata_o = mem_q[raddr_i];
    assign rfull_o = full_q[raddr_i];
    assign full_o  = full_q;
endmodule

// File: rtl/nanci_sort_collector.sv
// nanci_sort_collector: files PE {addr, data} words into address-indexed slots, then drains them in address order.
// Ports: clk, rst_n (async low); bus (slave modport): i_PE/i_capture capture, i_start arm, i_flush early drain,
//        o_word/o_valid/i_ready drain stream, o_done end pulse, o_busy, o_count filled slots, o_err sticky error.
module nanci_sort_collector
    import nanci_pkg::*;
#(
    parameter int N          = 8,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter logic [ADDR_WIDTH+DATA_WIDTH-1:0] MAX_INT = '1
) (
    input  logic clk,
    input  logic rst_n,
    nanci_sort_collector_if.slave bus
);
    localparam int W    = ADDR_WIDTH + DATA_WIDTH;
    localparam int CW   = $clog2(N + 1);
    localparam int ALSB = addr_lsb(DATA_WIDTH);
    localparam int AMSB = addr_msb(ADDR_WIDTH, DATA_WIDTH);
    localparam logic [ADDR_WIDTH-1:0] LAST  = ADDR_WIDTH'(N - 1);
    localparam logic [ADDR_WIDTH:0]   NSLOT = (ADDR_WIDTH + 1)'(N);
    localparam logic [CW-1:0]         NFULL = CW'(N);

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] ptr_q, ptr_d;
    logic [W-1:0]          word_q, word_d;
    logic                  valid_q, valid_d;
    logic                  done_q, done_d;
    logic [CW-1:0]         count_q, count_d;
    logic                  err_q, err_d;

    logic [ADDR_WIDTH-1:0] cap_addr, rd_addr;
    logic [DATA_WIDTH-1:0] cap_data, rd_data;
    logic [N-1:0]          full_map;
    logic                  rd_full, start_ok, cap_v, oor, dup, wr_en, xfer;
    logic [W-1:0]          rd_word;

    assign cap_addr = bus.i_PE[AMSB:ALSB];
    assign cap_data = bus.i_PE[DATA_WIDTH-1:0];
    assign start_ok = state_q == IDLE && bus.i_start;
    assign cap_v    = state_q == COLLECT && bus.i_capture && bus.i_PE != MAX_INT;
    assign oor      = {1'b0, cap_addr} >= NSLOT;
    assign dup      = !oor && full_map[cap_addr];
    assign wr_en    = cap_v && !oor && !dup;
    assign xfer     = valid_q && bus.i_ready;
    // While a word is displayed, prefetch the following slot so it loads on the transfer edge.
    assign rd_addr  = (valid_q && ptr_q != LAST) ? ptr_q + ADDR_WIDTH'(1) : ptr_q;
    assign rd_word  = rd_full ? {rd_addr, rd_data} : MAX_INT;
    assign count_d  = start_ok ? '0 : count_q + CW'(wr_en);
    assign err_d    = start_ok ? 1'b0 : err_q | (cap_v && (oor || dup));

    nanci_slot_bank #(
        .N(N), .ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH)
    ) u_bank (
        .clk(clk), .rst_n(rst_n), .clr_i(start_ok),
        .we_i(wr_en), .waddr_i(cap_addr), .wdata_i(cap_data),
        .raddr_i(rd_addr), .rdata_o(rd_data), .rfull_o(rd_full), .full_o(full_map)
    );

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        word_d  = word_q;
        valid_d = valid_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: state_d = bus.i_start ? COLLECT : IDLE;
            COLLECT: begin
                // A capture in the flush cycle is already folded into count_d and the bank write.
                if (bus.i_flush || count_d == NFULL) begin
                    state_d = DRAIN;
                    ptr_d   = '0;
                end
            end
            DRAIN: begin
                // valid_q low in DRAIN only happens on the first cycle: present slot 0.
                if (!valid_q) begin
                    valid_d = 1'b1;
                    word_d  = rd_word;
                end else if (xfer && ptr_q == LAST) begin
                    valid_d = 1'b0;
                    done_d  = 1'b1;
                    state_d = IDLE;
                end else if (xfer) begin
                    ptr_d  = ptr_q + ADDR_WIDTH'(1);
                    word_d = rd_word;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            word_q  <= '0;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
            count_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            word_q  <= word_d;
            valid_q <= valid_d;
            done_q  <= done_d;
            count_q <= count_d;
            err_q   <= err_d;
        end
    end

    assign bus.o_word  = word_q;
    assign bus.o_valid = valid_q;
    assign bus.o_done  = done_q;
    assign bus.o_busy  = state_q != IDLE;
    assign bus.o_count = count_q;
    assign bus.o_err   = err_q;
endmodule

// File: tb/tb_nanci_sort_collector.sv
// tb_nanci_sort_collector: table-driven collect/drain vectors plus directed corner-case sequences.
module tb_nanci_sort_collector;
    import nanci_pkg::*;
    localparam logic [5:0] PAD = DEF_MAX_INT;

    typedef struct packed {
        logic [3:0]      ncap;
        logic [7:0][5:0] cap;
        logic            flush;
        logic [7:0][5:0] exp;
        logic [3:0]      cnt;
        logic            err;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int checks = 0;
    int errors = 0;
    vec_t vecs[4];

    always #5 clk = ~clk;

    nanci_sort_collector_if #(.N(8), .ADDR_WIDTH(3), .DATA_WIDTH(3)) bus ();
    nanci_sort_collector #(.N(8), .ADDR_WIDTH(3), .DATA_WIDTH(3)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic start_run();
        bus.i_start = 1'b1;
        step();
        bus.i_start = 1'b0;
        chk("busy_after_start", {31'd0, bus.o_busy}, 1);
        chk("count_cleared", {28'd0, bus.o_count}, 0);
        chk("err_cleared", {31'd0, bus.o_err}, 0);
    endtask

    task automatic capture(input logic [5:0] w);
        bus.i_PE = w;
        bus.i_capture = 1'b1;
        step();
        bus.i_capture = 1'b0;
    endtask

    task automatic flush();
        bus.i_flush = 1'b1;
        step();
        bus.i_flush = 1'b0;
    endtask

    task automatic first_word_latency();
        chk("drain_entry_valid", {31'd0, bus.o_valid}, 0);
        chk("drain_entry_busy", {31'd0, bus.o_busy}, 1);
        step();
        chk("first_word_valid", {31'd0, bus.o_valid}, 1);
    endtask

    task automatic drain(input logic [7:0][5:0] exp, input bit bp);
        int w;
        for (int k = 0; k < 8; k++) begin
            w = 0;
            while (!bus.o_valid && w < 20) begin
                step();
                w++;
            end
            chk("drain_valid", {31'd0, bus.o_valid}, 1);
            chk("drain_word", {26'd0, bus.o_word}, {26'd0, exp[k]});
            chk("no_early_done", {31'd0, bus.o_done}, 0);
            if (bp) begin
                bus.i_ready = 1'b0;
                step();
                chk("hold_valid", {31'd0, bus.o_valid}, 1);
                chk("hold_word", {26'd0, bus.o_word}, {26'd0, exp[k]});
            end
            bus.i_ready = 1'b1;
            step();
        end
        bus.i_ready = 1'b0;
        chk("last_valid_drop", {31'd0, bus.o_valid}, 0);
        chk("done_pulse", {31'd0, bus.o_done}, 1);
        chk("busy_end", {31'd0, bus.o_busy}, 0);
        step();
        chk("done_one_cycle", {31'd0, bus.o_done}, 0);
    endtask

    task automatic chk_zero(input string name);
        chk({name, "_word"}, {26'd0, bus.o_word}, 0);
        chk({name, "_valid"}, {31'd0, bus.o_valid}, 0);
        chk({name, "_done"}, {31'd0, bus.o_done}, 0);
        chk({name, "_busy"}, {31'd0, bus.o_busy}, 0);
        chk({name, "_count"}, {28'd0, bus.o_count}, 0);
        chk({name, "_err"}, {31'd0, bus.o_err}, 0);
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        bus.i_PE = '0;
        bus.i_start = 1'b0;
        bus.i_capture = 1'b0;
        bus.i_flush = 1'b0;
        bus.i_ready = 1'b0;
        vecs[0] = '{ncap: 4'd8, cap: {6'o07, 6'o16, 6'o25, 6'o34, 6'o43, 6'o52, 6'o61, 6'o70}, flush: 1'b0,
                    exp: {6'o70, 6'o61, 6'o52, 6'o43, 6'o34, 6'o25, 6'o16, 6'o07}, cnt: 4'd8, err: 1'b0};
        vecs[1] = '{ncap: 4'd2, cap: {36'd0, 6'o03, 6'o05}, flush: 1'b1,
                    exp: {PAD, PAD, PAD, PAD, PAD, PAD, PAD, 6'o05}, cnt: 4'd1, err: 1'b1};
        vecs[2] = '{ncap: 4'd3, cap: {30'd0, PAD, PAD, PAD}, flush: 1'b1,
                    exp: {PAD, PAD, PAD, PAD, PAD, PAD, PAD, PAD}, cnt: 4'd0, err: 1'b0};
        vecs[3] = '{ncap: 4'd3, cap: {30'd0, 6'o12, 6'o64, 6'o31}, flush: 1'b1,
                    exp: {PAD, 6'o64, PAD, PAD, 6'o31, PAD, 6'o12, PAD}, cnt: 4'd3, err: 1'b0};
        #1;
        chk_zero("reset");
        #12 rst_n = 1'b1;
        step();
        bus.i_PE = 6'o00;
        bus.i_capture = 1'b1;
        bus.i_flush = 1'b1;
        step();
        bus.i_capture = 1'b0;
        bus.i_flush = 1'b0;
        chk("idle_ignore_busy", {31'd0, bus.o_busy}, 0);
        chk("idle_ignore_count", {28'd0, bus.o_count}, 0);
        chk("idle_ignore_valid", {31'd0, bus.o_valid}, 0);
        for (int v = 0; v < 4; v++) begin
            start_run();
            for (int i = 0; i < 8; i++) if (i < int'(vecs[v].ncap)) capture(vecs[v].cap[i]);
            if (vecs[v].flush) flush();
            first_word_latency();
            drain(vecs[v].exp, 1'b0);
            chk("vec_count", {28'd0, bus.o_count}, {28'd0, vecs[v].cnt});
            chk("vec_err", {31'd0, bus.o_err}, {31'd0, vecs[v].err});
        end
        start_run();
        for (int i = 0; i < 8; i++) capture(vecs[0].cap[i]);
        first_word_latency();
        drain(vecs[0].exp, 1'b1);
        chk("bp_count", {28'd0, bus.o_count}, 8);
        start_run();
        bus.i_PE = 6'o21;
        bus.i_capture = 1'b1;
        bus.i_flush = 1'b1;
        step();
        bus.i_capture = 1'b0;
        bus.i_flush = 1'b0;
        chk("simul_count", {28'd0, bus.o_count}, 1);
        first_word_latency();
        drain({PAD, PAD, PAD, PAD, PAD, 6'o21, PAD, PAD}, 1'b0);
        start_run();
        capture(6'o05);
        bus.i_start = 1'b1;
        step();
        bus.i_start = 1'b0;
        chk("start_in_collect_ignored", {28'd0, bus.o_count}, 1);
        capture(6'o05);
        chk("dup_err", {31'd0, bus.o_err}, 1);
        flush();
        first_word_latency();
        bus.i_ready = 1'b1;
        for (int i = 0; i < 3; i++) step();
        bus.i_ready = 1'b0;
        chk("pre_reset_word", {26'd0, bus.o_word}, {26'd0, PAD});
        #2 rst_n = 1'b0;
        #1;
        chk_zero("mid_reset");
        @(posedge clk);
        #1 rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("no_done_after_reset", {31'd0, bus.o_done}, 0);
        end
        start_run();
        chk("fresh_valid", {31'd0, bus.o_valid}, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
